// File: rtl/elevator_pkg.sv
// Shared state type and floor encoding for the elevator controller and the
// VGA display stage that consumes now_floor.
package elevator_pkg;

  localparam int N_FLOORS = 4;
  localparam int FLOOR_W  = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } elev_state_e;

  localparam logic [FLOOR_W-1:0] FLOOR_1   = 2'd0;
  localparam logic [FLOOR_W-1:0] FLOOR_2   = 2'd1;
  localparam logic [FLOOR_W-1:0] FLOOR_3   = 2'd2;
  localparam logic [FLOOR_W-1:0] FLOOR_4   = 2'd3;
  localparam logic [FLOOR_W-1:0] FLOOR_BOT = FLOOR_1;
  localparam logic [FLOOR_W-1:0] FLOOR_TOP = FLOOR_4;

  // Request bits strictly above / below floor f.
  function automatic logic [N_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    case (f)
      FLOOR_1: above_mask = 4'b1110;
      FLOOR_2: above_mask = 4'b1100;
      FLOOR_3: above_mask = 4'b1000;
      default: above_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [N_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    case (f)
      FLOOR_1: below_mask = 4'b0000;
      FLOOR_2: below_mask = 4'b0001;
      FLOOR_3: below_mask = 4'b0011;
      default: below_mask = 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Up-counter shared by travel and door timing: synchronous clear back to 0,
// terminal-count flag when the count equals tc_val.
module elev_timer #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/elevator_floor_ctrl.sv
// Four-floor elevator car controller: latches calls, moves the car with a
// SCAN policy and times floor travel and door dwell.
//
//   state     | meaning
//   IDLE      | parked, door closed, waiting for a request
//   MOVE_UP   | travelling one floor up per FLOOR_CYCLES
//   MOVE_DOWN | travelling one floor down per FLOOR_CYCLES
//   DOOR_OPEN | stopped at now_floor, door open for DOOR_CYCLES
module elevator_floor_ctrl
  import elevator_pkg::*;
#(
  parameter int FLOOR_CYCLES = 100_000_000,
  parameter int DOOR_CYCLES  = 200_000_000,
  parameter int CNT_W        = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [1:0] now_floor,
  output logic       dir_up,
  output logic       moving,
  output logic       door_open,
  output logic [3:0] req_pending
);

  elev_state_e       state_q, state_d;
  logic [1:0]        floor_q, floor_d;
  logic              dir_q, dir_d;
  logic              moving_q, moving_d;
  logic              door_q, door_d;
  logic [3:0]        req_q, req_d;
  logic [1:0]        next_floor;
  logic              above, below, here_btn, going_up, at_end;
  logic              timer_clr, timer_en, timer_tc;
  logic [CNT_W-1:0]  tc_val;

  assign tc_val   = (state_q == DOOR_OPEN) ? CNT_W'(DOOR_CYCLES - 1) : CNT_W'(FLOOR_CYCLES - 1);
  assign timer_en = (state_q != IDLE);

  elev_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .tc_val (tc_val),
    .tc     (timer_tc)
  );

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    req_d      = req_q | btn;
    timer_clr  = 1'b0;
    next_floor = floor_q;
    above      = |(req_q & above_mask(floor_q));
    below      = |(req_q & below_mask(floor_q));
    here_btn   = btn[floor_q];
    going_up   = (state_q == MOVE_UP);
    at_end     = going_up ? (floor_q == FLOOR_TOP) : (floor_q == FLOOR_BOT);

    case (state_q)
      IDLE: begin
        timer_clr = 1'b1;
        if (here_btn) begin
          // A call at the parked floor just opens the door; it is never queued.
          state_d             = DOOR_OPEN;
          req_d[floor_q]      = req_q[floor_q];
        end else if (above && below) begin
          state_d = dir_q ? MOVE_UP : MOVE_DOWN;
        end else if (above) begin
          state_d = MOVE_UP;
          dir_d   = 1'b1;
        end else if (below) begin
          state_d = MOVE_DOWN;
          dir_d   = 1'b0;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (timer_tc) begin
          timer_clr = 1'b1;
          if (at_end) begin
            state_d = IDLE;
          end else begin
            next_floor = going_up ? floor_q + 2'd1 : floor_q - 2'd1;
            floor_d    = next_floor;
            if (req_q[next_floor]) begin
              state_d           = DOOR_OPEN;
              req_d[next_floor] = 1'b0;
            end else if (going_up ? (next_floor == FLOOR_TOP) : (next_floor == FLOOR_BOT)) begin
              state_d = IDLE;
            end
          end
        end
      end

      DOOR_OPEN: begin
        if (here_btn) begin
          timer_clr      = 1'b1;
          req_d[floor_q] = req_q[floor_q];
        end else if (timer_tc) begin
          timer_clr = 1'b1;
          if (dir_q ? above : below) begin
            state_d = dir_q ? MOVE_UP : MOVE_DOWN;
          end else if (dir_q ? below : above) begin
            state_d = dir_q ? MOVE_DOWN : MOVE_UP;
            dir_d   = ~dir_q;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    moving_d = (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
    door_d   = (state_d == DOOR_OPEN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      floor_q  <= FLOOR_1;
      dir_q    <= 1'b1;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      door_q   <= door_d;
      req_q    <= req_d;
    end
  end

  assign now_floor   = floor_q;
  assign dir_up      = dir_q;
  assign moving      = moving_q;
  assign door_open   = door_q;
  assign req_pending = req_q;

endmodule

// File: doc/elevator_floor_ctrl.md
Name: elevator_floor_ctrl

Overview:
- Elevator car controller for the 4-floor system.
- Latches hall/car call buttons, schedules car motion with a SCAN policy, times floor-to-floor travel and door dwell.
- Produces the 2-bit `now_floor` consumed by the VGA display stage, plus status for LEDs/7-seg.
- Sits directly upstream of the display: its `now_floor` output drives the display's floor-image select.

Parameters:
- FLOOR_CYCLES, 100_000_000, clk cycles to travel one floor (1 s at 100 MHz); minimum 2.
- DOOR_CYCLES, 200_000_000, clk cycles the door stays open per stop; minimum 2.
- CNT_W, 28, counter width; must hold max(FLOOR_CYCLES, DOOR_CYCLES)-1.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-low reset.
- btn  in  4  call requests, one bit per floor (bit0 = floor 1); single-cycle pulses from upstream one-pulse logic; a held level is tolerated.
- now_floor  out  2  current car floor, 0..3 (2'b00 = floor 1).
- dir_up  out  1  1 = last/current travel direction is up.
- moving  out  1  1 in MOVE_UP/MOVE_DOWN.
- door_open  out  1  1 in DOOR_OPEN.
- req_pending  out  4  latched, unserved requests.

Behaviour:
- All outputs are registered.
- Async reset (rst=0): state=IDLE, now_floor=0, dir_up=1, moving=0, door_open=0, req_pending=0, counter=0.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- Derived signals from the registered req: above = |req[3:now_floor+1], below = |req[now_floor-1:0]. Both are 0 at the ends (floor 3 / floor 0).

Request latching:
- Each edge: req <= req | btn.
- Exception: btn[now_floor] in IDLE or DOOR_OPEN is not latched. It forces DOOR_OPEN and reloads the door counter at the next edge.
- btn[now_floor] during MOVE is latched; it is served on a return trip.

IDLE:
- If above and below are both set: go MOVE_UP if dir_up=1, else MOVE_DOWN.
- Else if above only: MOVE_UP, dir_up<=1.
- Else if below only: MOVE_DOWN, dir_up<=0.
- Else stay in IDLE.
- Latency: btn pulse at edge t appears in req_pending after t; the state leaves IDLE at edge t+1.

MOVE_x:
- Counter runs 0..FLOOR_CYCLES-1.
- At terminal count: now_floor<=now_floor±1 and counter<=0.
- Then, evaluated on the new floor: if req[new floor], go DOOR_OPEN and clear req[new floor] on the same edge. Otherwise continue in the same direction.
- moving=1 throughout.
- now_floor never wraps. MOVE_UP is never entered at floor 3 nor MOVE_DOWN at floor 0. If the next step would leave 0..3, go IDLE instead (defensive).

DOOR_OPEN:
- Counter runs 0..DOOR_CYCLES-1; door_open=1.
- At terminal count: if requests lie ahead in dir_up's direction, continue that way. Else if requests lie behind, reverse (update dir_up). Else go IDLE.
- Door re-open (btn[now_floor]) restarts the count at 0.

Simultaneous events:
- btn bit set on the same edge its floor is served: the clear wins for the current floor only; all other bits OR in normally.
- Multiple btn bits in one cycle are all latched.

Reset mid-operation: async, so every state and output returns to reset values immediately, with no completion of travel or door cycles.

Decomposition:
- Package elevator_pkg: state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN), N_FLOORS=4, FLOOR_W=2, the floor-encoding constants shared with the display stage.
- Sub-module elev_timer: loadable up-counter with clear and terminal-count flag, parameterised width; one instance, reloaded per state.
- Above/below reduction stays inline.

Test Plan (FLOOR_CYCLES=4, DOOR_CYCLES=6):
- Reset release, no btn, 50 cycles -> now_floor=0, state IDLE, all status 0, dir_up=1.
- Pulse btn=4'b1000 at floor 0 -> moving after 1 edge; now_floor increments every 4 cycles to 3 after 12 moving cycles; door_open=1 for 6 cycles; req_pending=0; then IDLE.
- Car at 3, pulse btn=4'b0001 then btn=4'b0100 during travel -> stops at floor 2 (door 6 cycles, req bit2 cleared), continues down to 0, dir_up=0 throughout.
- Car at 1 going up toward 3, pulse btn[0] -> serves 3 first, then reverses and serves 0 (SCAN); req_pending[0] held until arrival at floor 0.
- In DOOR_OPEN at floor 2, pulse btn[2] at door count 4 -> door stays open 6 more cycles (11 total); req_pending[2] remains 0.
- Assert rst=0 mid-travel between floors 1 and 2 -> outputs reset asynchronously: now_floor=0, moving=0, req_pending=0.
